// File: rtl/mirfak_dwb_sram_slave.sv
// Wishbone classic data-port SRAM responder: byte-lane writes, registered read data,
// programmable wait states, error on out-of-range access. Optional MIRFAK_DWB_ROM_PROTECT_EN.
module mirfak_dwb_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned MEM_SIZE    = 32'h0001_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned ROM_SIZE    = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dwbs_addr_i,
    input  logic [31:0] dwbs_dat_i,
    input  logic [3:0]  dwbs_sel_i,
    input  logic        dwbs_cyc_i,
    input  logic        dwbs_stb_i,
    input  logic        dwbs_we_i,
    output logic [31:0] dwbs_dat_o,
    output logic        dwbs_ack_o,
    output logic        dwbs_err_o
);

    localparam int unsigned DEPTH = MEM_SIZE / 4;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;
`ifdef MIRFAK_DWB_ROM_PROTECT_EN
    localparam bit ROM_PROTECT = 1'b1;
`else
    localparam bit ROM_PROTECT = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               we_q, we_d;
    logic               bad_q, bad_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        wdat_q, wdat_d;
    logic               ack_d, err_d;
    logic [31:0]        rdat_d;
    logic               done;
    logic               mem_we;

    logic [31:0]        mem [DEPTH];

    logic               req;
    logic [31:0]        offset;
    logic               in_range;
    logic               req_bad;
    logic [IDX_W-1:0]   req_idx;

    // Address decode; the 32-bit subtraction wraps, so addresses below the base fail the >= test.
    assign req      = dwbs_cyc_i && dwbs_stb_i;
    assign offset   = dwbs_addr_i - ADDR_BASE;
    assign in_range = (dwbs_addr_i >= ADDR_BASE) && (offset < MEM_SIZE);
    assign req_bad  = !in_range || (ROM_PROTECT && dwbs_we_i && (offset < ROM_SIZE));
    assign req_idx  = offset[IDX_W+1:2];

    // Next state and registered-output next values. The *_d payload is the access being completed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        bad_d   = bad_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d  = req_idx;
                    we_d   = dwbs_we_i;
                    bad_d  = req_bad;
                    sel_d  = dwbs_sel_i;
                    wdat_d = dwbs_dat_i;
                    cnt_d  = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        done    = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    done    = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ack_d  = done && !bad_d;
        err_d  = done && bad_d;
        mem_we = done && !bad_d && we_d && !rst_i;
        rdat_d = dwbs_dat_o;
        if (done) begin
            if (bad_d) begin
                rdat_d = '0;
            end else if (!we_d) begin
                rdat_d = mem[idx_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            bad_q      <= 1'b0;
            sel_q      <= '0;
            wdat_q     <= '0;
            dwbs_ack_o <= 1'b0;
            dwbs_err_o <= 1'b0;
            dwbs_dat_o <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            bad_q      <= bad_d;
            sel_q      <= sel_d;
            wdat_q     <= wdat_d;
            dwbs_ack_o <= ack_d;
            dwbs_err_o <= err_d;
            dwbs_dat_o <= rdat_d;
        end
    end

    // Storage is never reset; a write in flight during reset is dropped via mem_we.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int n = 0; n < 4; n++) begin
                if (sel_d[n]) begin
                    mem[idx_d][8*n +: 8] <= wdat_d[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mirfak_dwb_sram_slave.sv
// Directed bench for mirfak_dwb_sram_slave: one zero-wait instance at base 0 and one
// three-wait instance at base 0x1000 to exercise wrap, wait states, abort and reset.
module tb_mirfak_dwb_sram_slave;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic [3:0]  sel  [2];
    logic        cyc  [2];
    logic        stb  [2];
    logic        we   [2];
    logic        ack  [2];
    logic        err  [2];

    int   passed = 0;
    int   total  = 0;
    logic pulse_left;

    always #5 clk_i = ~clk_i;

    mirfak_dwb_sram_slave #(
        .ADDR_BASE(32'h0000_0000), .MEM_SIZE(32'h0001_0000),
        .WAIT_STATES(0), .ROM_SIZE(32'h0000_1000)
    ) dut0 (
        .clk_i(clk_i), .rst_i(rst_i),
        .dwbs_addr_i(addr[0]), .dwbs_dat_i(wdat[0]), .dwbs_sel_i(sel[0]),
        .dwbs_cyc_i(cyc[0]), .dwbs_stb_i(stb[0]), .dwbs_we_i(we[0]),
        .dwbs_dat_o(rdat[0]), .dwbs_ack_o(ack[0]), .dwbs_err_o(err[0])
    );

    mirfak_dwb_sram_slave #(
        .ADDR_BASE(32'h0000_1000), .MEM_SIZE(32'h0000_1000),
        .WAIT_STATES(3), .ROM_SIZE(32'h0000_0000)
    ) dut1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .dwbs_addr_i(addr[1]), .dwbs_dat_i(wdat[1]), .dwbs_sel_i(sel[1]),
        .dwbs_cyc_i(cyc[1]), .dwbs_stb_i(stb[1]), .dwbs_we_i(we[1]),
        .dwbs_dat_o(rdat[1]), .dwbs_ack_o(ack[1]), .dwbs_err_o(err[1])
    );

    // One access on port p; lat counts edges from the sampling edge to the first ack/err (20 = timeout).
    task automatic bus(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic ok, output logic bad,
                       output logic [31:0] rd, output int lat);
        @(negedge clk_i);
        cyc[p] = 1'b1; stb[p] = 1'b1; we[p] = w; addr[p] = a; wdat[p] = d; sel[p] = s;
        ok = 1'b0; bad = 1'b0; rd = '0; lat = 20;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk_i); #1;
            if (ack[p] || err[p]) begin
                ok = ack[p]; bad = err[p]; rd = rdat[p]; lat = i;
                break;
            end
        end
        cyc[p] = 1'b0; stb[p] = 1'b0;
        @(posedge clk_i); #1;
        pulse_left = ack[p] | err[p];
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk_i); #1;
            total++; if ({ack[0], err[0], rdat[0]} !== 34'h0) $display("FAIL reset0 cyc%0d ack=%b err=%b dat=%h exp 0/0/0", c, ack[0], err[0], rdat[0]); else passed++;
            total++; if ({ack[1], err[1], rdat[1]} !== 34'h0) $display("FAIL reset1 cyc%0d ack=%b err=%b dat=%h exp 0/0/0", c, ack[1], err[1], rdat[1]); else passed++;
        end
        @(negedge clk_i); rst_i = 1'b0;
        @(posedge clk_i); #1;
        total++; if ({ack[0], err[0], rdat[0]} !== 34'h0) $display("FAIL idle_after_reset ack=%b err=%b dat=%h exp 0/0/0", ack[0], err[0], rdat[0]); else passed++;
    endtask

    task automatic test_word_rw();
        logic ok, bad; logic [31:0] rd; int lat;
        bus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ok, bad, rd, lat);
        total++; if ({ok, bad} !== 2'b10) $display("FAIL wr_ack ack/err=%b%b exp 10", ok, bad); else passed++;
        total++; if (lat !== 1) $display("FAIL wr_latency got=%0d exp 1", lat); else passed++;
        total++; if (pulse_left !== 1'b0) $display("FAIL wr_pulse_width second cycle=%b exp 0", pulse_left); else passed++;
        bus(0, 1'b0, 32'h10, 32'h0, 4'hF, ok, bad, rd, lat);
        total++; if ({ok, bad} !== 2'b10 || lat !== 1) $display("FAIL rd_ack ack/err=%b%b lat=%0d exp 10 lat 1", ok, bad, lat); else passed++;
        total++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data got=%h exp deadbeef", rd); else passed++;
    endtask

    task automatic test_byte_lanes();
        logic ok, bad; logic [31:0] rd; int lat;
        bus(0, 1'b1, 32'h20, 32'h11223344, 4'hF, ok, bad, rd, lat);
        total++; if (rd !== 32'hDEADBEEF) $display("FAIL wr_keeps_dat got=%h exp deadbeef", rd); else passed++;
        bus(0, 1'b1, 32'h22, 32'hAABBCCDD, 4'b0110, ok, bad, rd, lat);
        total++; if (ok !== 1'b1) $display("FAIL lane_wr_ack got=%b exp 1", ok); else passed++;
        bus(0, 1'b0, 32'h20, 32'h0, 4'b0001, ok, bad, rd, lat);
        total++; if (rd !== 32'h11BBCC44) $display("FAIL lane_merge got=%h exp 11bbcc44", rd); else passed++;
        bus(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, ok, bad, rd, lat);
        total++; if ({ok, bad} !== 2'b10) $display("FAIL sel0_ack ack/err=%b%b exp 10", ok, bad); else passed++;
        bus(0, 1'b0, 32'h20, 32'h0, 4'hF, ok, bad, rd, lat);
        total++; if (rd !== 32'h11BBCC44) $display("FAIL sel0_nochange got=%h exp 11bbcc44", rd); else passed++;
    endtask

    task automatic test_out_of_range();
        logic ok, bad; logic [31:0] rd; int lat;
        bus(0, 1'b1, 32'hFFFC, 32'h0F0F0F0F, 4'hF, ok, bad, rd, lat);
        bus(0, 1'b0, 32'h0001_0000, 32'h0, 4'hF, ok, bad, rd, lat);
        total++; if ({ok, bad} !== 2'b01 || lat !== 1) $display("FAIL oor_rd ack/err=%b%b lat=%0d exp 01 lat 1", ok, bad, lat); else passed++;
        total++; if (rd !== 32'h0) $display("FAIL oor_dat got=%h exp 0", rd); else passed++;
        total++; if (pulse_left !== 1'b0) $display("FAIL oor_pulse_width got=%b exp 0", pulse_left); else passed++;
        bus(0, 1'b1, 32'hFFFF_FFFC, 32'h5555AAAA, 4'hF, ok, bad, rd, lat);
        total++; if ({ok, bad} !== 2'b01) $display("FAIL oor_wr_top ack/err=%b%b exp 01", ok, bad); else passed++;
        bus(0, 1'b0, 32'hFFFC, 32'h0, 4'hF, ok, bad, rd, lat);
        total++; if ({ok, bad} !== 2'b10 || rd !== 32'h0F0F0F0F) $display("FAIL last_word ack/err=%b%b dat=%h exp 10 0f0f0f0f", ok, bad, rd); else passed++;
        bus(1, 1'b0, 32'h0FFC, 32'h0, 4'hF, ok, bad, rd, lat);
        total++; if ({ok, bad} !== 2'b01) $display("FAIL below_base ack/err=%b%b exp 01", ok, bad); else passed++;
        bus(1, 1'b0, 32'h2000, 32'h0, 4'hF, ok, bad, rd, lat);
        total++; if ({ok, bad} !== 2'b01) $display("FAIL above_top ack/err=%b%b exp 01", ok, bad); else passed++;
    endtask

    // A request held through RESP is re-sampled only in IDLE: ack pattern 1,0,1,0.
    task automatic test_back_to_back();
        logic [3:0] pat;
        @(negedge clk_i);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; sel[0] = 4'hF;
        for (int i = 3; i >= 0; i--) begin
            @(posedge clk_i); #1;
            pat[i] = ack[0];
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(posedge clk_i); #1;
        total++; if (pat !== 4'b1010) $display("FAIL held_req_ack got=%b exp 1010", pat); else passed++;
        total++; if (rdat[0] !== 32'hDEADBEEF) $display("FAIL held_req_dat got=%h exp deadbeef", rdat[0]); else passed++;
    endtask

    task automatic test_wait_states();
        logic ok, bad, seen; logic [31:0] rd; int lat;
        bus(1, 1'b1, 32'h1040, 32'hCAFEF00D, 4'hF, ok, bad, rd, lat);
        total++; if ({ok, bad} !== 2'b10 || lat !== 4) $display("FAIL ws_wr ack/err=%b%b lat=%0d exp 10 lat 4", ok, bad, lat); else passed++;
        bus(1, 1'b0, 32'h1040, 32'h0, 4'hF, ok, bad, rd, lat);
        total++; if (lat !== 4 || rd !== 32'hCAFEF00D) $display("FAIL ws_rd lat=%0d dat=%h exp 4 cafef00d", lat, rd); else passed++;
        total++; if (pulse_left !== 1'b0) $display("FAIL ws_pulse_width got=%b exp 0", pulse_left); else passed++;
        // Abort: strobe drops one edge after the sampling edge.
        @(negedge clk_i);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h1040; wdat[1] = 32'hBAD0BAD0; sel[1] = 4'hF;
        @(posedge clk_i);
        @(posedge clk_i); #1;
        seen = ack[1] | err[1];
        stb[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #1;
            seen |= ack[1] | err[1];
        end
        cyc[1] = 1'b0;
        total++; if (seen !== 1'b0) $display("FAIL abort_no_resp got=%b exp 0", seen); else passed++;
        bus(1, 1'b1, 32'h1040, 32'h12345678, 4'b0011, ok, bad, rd, lat);
        total++; if ({ok, bad} !== 2'b10 || lat !== 4) $display("FAIL post_abort_wr ack/err=%b%b lat=%0d exp 10 lat 4", ok, bad, lat); else passed++;
        bus(1, 1'b0, 32'h1040, 32'h0, 4'hF, ok, bad, rd, lat);
        total++; if (rd !== 32'hCAFE5678) $display("FAIL post_abort_rd got=%h exp cafe5678", rd); else passed++;
    endtask

    task automatic test_rom_region();
        logic ok, bad; logic [31:0] rd, r0; int lat;
`ifdef MIRFAK_DWB_ROM_PROTECT_EN
        bus(0, 1'b0, 32'h0FFC, 32'h0, 4'hF, ok, bad, r0, lat);
        total++; if ({ok, bad} !== 2'b10) $display("FAIL rom_rd ack/err=%b%b exp 10", ok, bad); else passed++;
        bus(0, 1'b0, 32'h10, 32'h0, 4'hF, ok, bad, rd, lat);
        bus(0, 1'b1, 32'h0FFC, 32'h12345678, 4'hF, ok, bad, rd, lat);
        total++; if ({ok, bad} !== 2'b01 || lat !== 1 || rd !== 32'h0) $display("FAIL rom_wr ack/err=%b%b lat=%0d dat=%h exp 01 lat 1 0", ok, bad, lat, rd); else passed++;
        bus(0, 1'b0, 32'h0FFC, 32'h0, 4'hF, ok, bad, rd, lat);
        total++; if (rd !== r0) $display("FAIL rom_kept got=%h exp %h", rd, r0); else passed++;
        bus(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, ok, bad, rd, lat);
        total++; if ({ok, bad} !== 2'b10) $display("FAIL above_rom_wr ack/err=%b%b exp 10", ok, bad); else passed++;
        bus(0, 1'b0, 32'h1000, 32'h0, 4'hF, ok, bad, rd, lat);
        total++; if (rd !== 32'h12345678) $display("FAIL above_rom_rd got=%h exp 12345678", rd); else passed++;
`else
        r0 = 32'h0;
        bus(0, 1'b1, 32'h0FFC, 32'h12345678, 4'hF, ok, bad, rd, lat);
        total++; if ({ok, bad} !== 2'b10) $display("FAIL low_wr ack/err=%b%b exp 10", ok, bad); else passed++;
        bus(0, 1'b0, 32'h0FFC, 32'h0, 4'hF, ok, bad, rd, lat);
        total++; if (rd !== 32'h12345678) $display("FAIL low_rd got=%h exp 12345678 (prev %h)", rd, r0); else passed++;
        bus(0, 1'b1, 32'h1000, 32'h87654321, 4'hF, ok, bad, rd, lat);
        bus(0, 1'b0, 32'h1000, 32'h0, 4'hF, ok, bad, rd, lat);
        total++; if (rd !== 32'h87654321) $display("FAIL w1000_rd got=%h exp 87654321", rd); else passed++;
`endif
    endtask

    // Reset one edge into a waited write: outputs clear and the write is dropped.
    task automatic test_reset_mid_op();
        logic ok, bad; logic [31:0] rd; int lat;
        @(negedge clk_i);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h1040; wdat[1] = 32'hFFFFFFFF; sel[1] = 4'hF;
        @(posedge clk_i);
        @(negedge clk_i); rst_i = 1'b1;
        @(posedge clk_i); #1;
        total++; if ({ack[1], err[1], rdat[1]} !== 34'h0) $display("FAIL mid_reset ack=%b err=%b dat=%h exp 0/0/0", ack[1], err[1], rdat[1]); else passed++;
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk_i); rst_i = 1'b0;
        bus(1, 1'b0, 32'h1040, 32'h0, 4'hF, ok, bad, rd, lat);
        total++; if ({ok, bad} !== 2'b10 || rd !== 32'hCAFE5678) $display("FAIL mid_reset_dropped ack/err=%b%b dat=%h exp 10 cafe5678", ok, bad, rd); else passed++;
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            cyc[p] = 1'b0; stb[p] = 1'b0; we[p] = 1'b0;
            addr[p] = '0; wdat[p] = '0; sel[p] = '0;
        end
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_out_of_range();
        test_back_to_back();
        test_wait_states();
        test_rom_region();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mirfak_dwb_sram_slave.md
Name: mirfak_dwb_sram_slave

Overview:
Wishbone classic data-port responder: word-organised on-chip SRAM with byte-lane writes, registered read data, programmable wait states and an error response for out-of-range addresses.
Sits on the far end of the core's data bus; the load/store unit's dwbm_* outputs connect directly to the dwbs_* inputs.
Used as the data memory in simulation and FPGA builds.

Parameters:
ADDR_BASE, 32'h0000_0000, byte address of first memory location; must be 4-byte aligned.
MEM_SIZE, 32'h0001_0000, memory size in bytes; power of two, >= 4.
WAIT_STATES, 0, extra cycles inserted before ack/err; 0..15.
ROM_SIZE, 32'h0000_1000, bytes of write-protected region at ADDR_BASE; used only when the optional feature is enabled; multiple of 4, <= MEM_SIZE.

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
dwbs_addr_i  input  32  byte address
dwbs_dat_i  input  32  write data
dwbs_sel_i  input  4  byte lane select; bit n covers dat[8n+7:8n]
dwbs_cyc_i  input  1  bus cycle valid
dwbs_stb_i  input  1  strobe
dwbs_we_i  input  1  1=write, 0=read
dwbs_dat_o  output  32  read data, registered
dwbs_ack_o  output  1  normal termination, registered, one-cycle pulse
dwbs_err_o  output  1  error termination, registered, one-cycle pulse

Behaviour:
- Clock and reset: one clock (clk_i); reset (rst_i) is synchronous and active-high.
- Reset values: state=IDLE, wait counter=0, dwbs_ack_o=0, dwbs_err_o=0, dwbs_dat_o=0. Memory contents are not reset.
- Request: a request is valid when dwbs_cyc_i && dwbs_stb_i.
- Address decode:
  - in_range = (addr >= ADDR_BASE) && (addr - ADDR_BASE < MEM_SIZE).
  - word index = (addr - ADDR_BASE) >> 2.
  - addr[1:0] is ignored; dwbs_sel_i alone selects the lanes.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on a valid request, latch addr, we, sel, dat and the in_range/error decision. Load the wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else complete the access on that same edge and go to RESP.
  - WAIT: counter decrements each cycle. When the counter reaches 1, complete the access on that edge and go to RESP. If dwbs_cyc_i or dwbs_stb_i drops while in WAIT, abort: go to IDLE, no memory write, no ack/err.
  - RESP: exactly one of dwbs_ack_o/dwbs_err_o is high for this single cycle. The next edge clears both and returns to IDLE unconditionally. A request still held high in RESP is not restarted until IDLE samples it.
- Completion of a valid, non-error access:
  - Write: memory[word][8n+7:8n] <= dat[8n+7:8n] for each set sel bit. sel=0000 still acks with no change. dwbs_dat_o is unchanged.
  - Read: dwbs_dat_o <= memory[word], all 32 bits regardless of sel. Set ack.
- Completion of an error access (out of range): set err, no memory change, dwbs_dat_o <= 0.
- Latency: a request first sampled at edge N produces ack/err high during the cycle after edge N+WAIT_STATES. Throughput is one access per WAIT_STATES+2 cycles.
- Read-after-write to the same word in back-to-back accesses returns the new data (the write completes before the next IDLE sample).
- Reset mid-operation: the next edge forces IDLE, clears ack/err, drops any pending write, and sets dwbs_dat_o=0.
- Address wrap: addr - ADDR_BASE is computed in 32 bits; an address below ADDR_BASE yields an error and never aliases.

Optional Feature:
Macro MIRFAK_DWB_ROM_PROTECT_EN.
- Defined: a write with (addr - ADDR_BASE) < ROM_SIZE and in_range terminates with err after the normal latency. Memory is unchanged and dwbs_dat_o <= 0. Reads of that region ack normally.
- Not defined: ROM_SIZE is ignored and all in-range writes succeed.

Test Plan:
- Reset then idle: rst_i high 2 cycles, cyc/stb low -> ack=0, err=0, dat_o=32'h0 every cycle.
- Word write then read, WAIT_STATES=0: write 32'hDEADBEEF to 0x0000_0010 with sel=1111 -> ack one cycle after sample. Read 0x10 -> dat_o=32'hDEADBEEF with ack, both in the same cycle.
- Byte lanes: word 0x20 = 32'h11223344, then write dat=32'hAABBCCDD with sel=0110 -> read 0x20 returns 32'h11BBCC44.
- Out of range, MEM_SIZE=0x10000: read 0x0001_0000 -> err pulse one cycle, ack=0, dat_o=0. A following read of 0x0000_FFFC acks normally.
- WAIT_STATES=3: read sampled at edge N -> ack high in the cycle after edge N+3 for exactly one cycle. In a second run, drop stb after edge N+1 -> no ack/err, FSM back to IDLE, and a follow-up write to the same word is not corrupted.
- MIRFAK_DWB_ROM_PROTECT_EN, ROM_SIZE=0x1000: write 32'h12345678 to 0x0000_0FFC -> err, and a later read returns the prior value. A write to 0x0000_1000 -> ack, and a read returns 32'h12345678.
